updown_timer_ctrl: RTL and testbench
====================================

Name: updown_timer_ctrl

Overview:
- Sequencing controller for a multi-digit BCD up/down count chain built from mod-10 decade cells.
- Owns start/pause/clear/load commands, a step prescaler, direction control, target compare, and terminal/wrap signalling.
- Sits between a button/command front end and the digit display path. It presents a registered BCD count and status flags.

Parameters:
- DIGITS, 2, number of BCD digits in the chain (1..4); the count width is 4*DIGITS.
- TICK_DIV, 4, clk cycles per count step (>=1); the prescaler runs 0..TICK_DIV-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin or resume counting (level, sampled each cycle)
- pause  in  1  hold count; prescaler frozen
- clear  in  1  force count to 0 and go to IDLE
- load  in  1  load load_val into count (IDLE/PAUSE/DONE only)
- load_val  in  4*DIGITS  BCD preload value
- dir  in  1  1 = up, 0 = down; sampled on every step
- target  in  4*DIGITS  BCD terminal value
- count  out  4*DIGITS  registered BCD count
- zero  out  1  registered; 1 when count == 0
- wrap  out  1  one-cycle pulse on 9..9->0..0 (up) or 0..0->9..9 (down)
- done  out  1  one-cycle pulse on reaching target
- busy  out  1  1 in RUN
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
Reset (rst=1 at posedge):
- count=0, zero=1, wrap=0, done=0, busy=0, state=IDLE, prescaler=0.
- Reset overrides every command, including in the middle of a run.

Command priority each cycle: rst > clear > load > pause > start.

Commands:
- clear: count=0, prescaler=0, state=IDLE. Takes effect in any state.
- load: accepted only in IDLE, PAUSE or DONE, and ignored in RUN.
  - count=load_val, with any digit >9 clamped to 9. prescaler=0.
  - State is unchanged, except DONE -> IDLE.

FSM transitions:
- IDLE -> RUN on start.
- RUN -> PAUSE on pause.
- RUN -> DONE on the step that makes count == target.
- PAUSE -> RUN on start with pause=0.
- DONE -> RUN on start, provided load/clear are not asserted. The count continues from target; no reload.

Prescaler and step:
- In RUN, the prescaler increments every cycle.
- When prescaler == TICK_DIV-1, a step occurs that cycle and the prescaler returns to 0.
- The first step therefore lands TICK_DIV cycles after entry to RUN.

Step arithmetic (per-digit mod-10 ripple):
- Up: digit 0 increments. A digit at 9 goes to 0 and carries to the next digit.
- Down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Carry out of the top digit is discarded and asserts wrap for one cycle, in the cycle count shows the wrapped value.

Target compare:
- Uses the post-step value.
- done pulses for one cycle, aligned with the new count, and state becomes DONE.
- If target == count when entering RUN, nothing happens until the count wraps back around to it.
- wrap and done may pulse in the same cycle, e.g. target=0 while counting up from 9..9.

Output timing:
- zero tracks the registered count with no extra latency; it is recomputed from the next-count value.
- busy = (state == RUN).
- dir changing between steps takes effect on the next step, with no glitch.
- start and pause both high: pause wins in RUN; in PAUSE, stay paused.

Decomposition:
- Shared package ctr_pkg holds:
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE;
  - BCD_MAX=4'd9;
  - a BCD clamp function.
- One natural sub-module, bcd_digit_step: a single decade digit with inputs en, dir, cur[3:0] and outputs nxt[3:0], cout.
  - It is purely combinational and generate-instantiated DIGITS times, with en chained from the lower digit's cout.
- The FSM, prescaler and compare stay in the top level.

Test Plan (DIGITS=2, TICK_DIV=4):
1. Reset → count=00, zero=1, state=IDLE. Then start, dir=1, target=05 → count steps 01..05, one step every 4 cycles; done pulses once with count=05; state=DONE; busy=0.
2. load 97, dir=1, target=02, start → 98, 99, 00 (wrap=1, zero=1), 01, 02 (done=1). wrap is high for exactly 1 cycle.
3. load 01, dir=0, target=98, start → 00 (zero=1), 99 (wrap=1), 98 (done=1).
4. RUN at 03 up. Assert pause 2 cycles after a step, hold 10 cycles → count holds at 03 and state=PAUSE. Release pause and assert start → next step to 04 lands exactly 4 cycles later.
5. RUN, load=1 with load_val=50 → ignored. Then clear=1 together with load=1 → count=00, state=IDLE (clear wins). load_val=A7 in IDLE → count=97 (clamped).
6. Mid-RUN count=42: rst=1 for 1 cycle → all outputs at reset values next cycle. start on the following cycle → first step to 01 after 4 cycles.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared definitions for the BCD up/down timer controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ctr_pkg;

    // Controller states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Force a nibble into the legal BCD range (A..F become 9).
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/updown_timer_ctrl_if.sv
// Command/status bundle between the command front end and the timer controller.
// Latency: n/a (wires only).
// Backpressure: none; commands are levels sampled every clock.
// Ports: start/pause/clear/load/dir/load_val/target go toward the controller,
//        count/zero/wrap/done/busy/state come back from it.
interface updown_timer_ctrl_if #(
    parameter int DIGITS = 2
);
    logic                  start;
    logic                  pause;
    logic                  clear;
    logic                  load;
    logic                  dir;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   target;
    logic [4*DIGITS-1:0]   count;
    logic                  zero;
    logic                  wrap;
    logic                  done;
    logic                  busy;
    logic [1:0]            state;

    // Command source side.
    modport master (
        output start, pause, clear, load, dir, load_val, target,
        input  count, zero, wrap, done, busy, state
    );

    // Controller side.
    modport slave (
        input  start, pause, clear, load, dir, load_val, target,
        output count, zero, wrap, done, busy, state
    );
endinterface

// File: rtl/bcd_digit_step.sv
// One mod-10 decade cell: steps a BCD digit up or down when enabled.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_en step enable (carry/borrow in), i_dir 1=up 0=down, i_cur current digit,
//        o_nxt stepped digit, o_cout carry/borrow out to the next decade.
module bcd_digit_step
    import ctr_pkg::*;
(
    input  logic       i_en,
    input  logic       i_dir,
    input  logic [3:0] i_cur,
    output logic [3:0] o_nxt,
    output logic       o_cout
);
    always_comb begin
        o_nxt  = i_cur;
        o_cout = 1'b0;
        if (i_en) begin
            if (i_dir) begin
                if (i_cur >= BCD_MAX) begin
                    o_nxt  = 4'd0;
                    o_cout = 1'b1;
                end else begin
                    o_nxt = i_cur + 4'd1;
                end
            end else begin
                if (i_cur == 4'd0) begin
                    o_nxt  = BCD_MAX;
                    o_cout = 1'b1;
                end else begin
                    o_nxt = i_cur - 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/updown_timer_ctrl.sv
// Sequencer for a DIGITS-wide BCD up/down count chain: commands, prescaler, target compare.
// Latency: all outputs registered; first step TICK_DIV cycles after entering RUN.
// Backpressure: none; commands are levels, priority rst > clear > load > pause > start.
// Ports: i_clk, i_rst (sync, active-high); bus (slave) carries commands in and
//        count/zero/wrap/done/busy/state out.
module updown_timer_ctrl
    import ctr_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    updown_timer_ctrl_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_count, w_count_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic            r_zero, r_wrap, r_done;
    logic            w_wrap_nxt, w_done_nxt;

    logic [W-1:0]    w_step_val;
    logic [W-1:0]    w_load_clamped;
    logic [DIGITS:0] w_chain;

    // Digit 0 always steps; each higher digit steps on the carry/borrow below it.
    assign w_chain[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_digit (
            .i_en   (w_chain[g]),
            .i_dir  (bus.dir),
            .i_cur  (r_count[4*g +: 4]),
            .o_nxt  (w_step_val[4*g +: 4]),
            .o_cout (w_chain[g+1])
        );
    end

    always_comb begin
        w_load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_clamped[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_zero  <= 1'b1;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_zero  <= (w_count_nxt == '0);
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (bus.clear) begin
            w_count_nxt = '0;
            w_presc_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else if (bus.load && (r_state != ST_RUN)) begin
            w_count_nxt = w_load_clamped;
            w_presc_nxt = '0;
            if (r_state == ST_DONE) begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.pause) begin
                        // Prescaler holds; it is restarted on resume anyway.
                        w_state_nxt = ST_PAUSE;
                    end else if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = '0;
                        w_count_nxt = w_step_val;
                        w_wrap_nxt  = w_chain[DIGITS];
                        // Compare on the post-step value so entering RUN at target
                        // does not fire until the count comes round again.
                        if (w_step_val == bus.target) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                ST_IDLE, ST_PAUSE, ST_DONE: begin
                    // Every entry to RUN starts a full step period, so the first
                    // step always lands TICK_DIV cycles later (also after a pause).
                    if (bus.start && !bus.pause) begin
                        w_state_nxt = ST_RUN;
                        w_presc_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bus.count = r_count;
    assign bus.zero  = r_zero;
    assign bus.wrap  = r_wrap;
    assign bus.done  = r_done;
    assign bus.busy  = (r_state == ST_RUN);
    assign bus.state = r_state;

endmodule

// File: tb/tb_updown_timer_ctrl.sv
module tb_updown_timer_ctrl;
    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MAXV     = 99;

    typedef struct {
        logic [W-1:0] count;
        logic         zero;
        logic         wrap;
        logic         done;
        logic         busy;
        logic [1:0]   state;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];

    updown_timer_ctrl_if #(.DIGITS(DIGITS)) bus();

    updown_timer_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int bcd_to_int(input logic [W-1:0] b);
        int v = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v += d * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    int m_v  = 0;   // count as a plain decimal number
    int m_st = 0;   // 0 idle, 1 run, 2 pause, 3 done
    int m_pc = 0;   // cycles spent in RUN since the last step or entry

    always @(posedge clk) begin : model
        exp_t e;
        bit   ew;
        bit   ed;
        ew = 1'b0;
        ed = 1'b0;
        if (rst || bus.clear) begin
            m_v = 0; m_st = 0; m_pc = 0;
        end else if (bus.load && m_st != 1) begin
            m_v = bcd_to_int(bus.load_val);
            m_pc = 0;
            if (m_st == 3) m_st = 0;
        end else if (m_st == 1) begin
            if (bus.pause) begin
                m_st = 2;
            end else begin
                m_pc++;
                if (m_pc == TICK_DIV) begin
                    m_pc = 0;
                    if (bus.dir) begin
                        if (m_v == MAXV) begin m_v = 0; ew = 1'b1; end
                        else m_v++;
                    end else begin
                        if (m_v == 0) begin m_v = MAXV; ew = 1'b1; end
                        else m_v--;
                    end
                    if (m_v == bcd_to_int(bus.target)) begin
                        ed = 1'b1;
                        m_st = 3;
                    end
                end
            end
        end else if (bus.start && !bus.pause) begin
            m_st = 1;
            m_pc = 0;
        end
        e.count = int_to_bcd(m_v);
        e.zero  = (m_v == 0);
        e.wrap  = ew;
        e.done  = ed;
        e.busy  = (m_st == 1);
        e.state = 2'(m_st);
        exp_q.push_back(e);
    end

    // ---------------- monitor: pops one expectation per output cycle ----------------
    initial begin : monitor
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry for DUT output", $time);
            end else begin
                e = exp_q.pop_front();
                if ({bus.count, bus.zero, bus.wrap, bus.done, bus.busy, bus.state} !==
                    {e.count, e.zero, e.wrap, e.done, e.busy, e.state}) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t got count=%h zero=%b wrap=%b done=%b busy=%b state=%0d, expected count=%h zero=%b wrap=%b done=%b busy=%b state=%0d",
                             $time, bus.count, bus.zero, bus.wrap, bus.done, bus.busy, bus.state,
                             e.count, e.zero, e.wrap, e.done, e.busy, e.state);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin : stim
        rst = 1'b1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
        bus.dir = 1'b1; bus.load_val = '0; bus.target = '0;
        wait_neg(2);
        rst = 1'b0;
        chk("reset_count", 32'(bus.count), 32'h00);
        chk("reset_zero",  32'(bus.zero),  32'd1);
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_busy",  32'(bus.busy),  32'd0);

        // 1: count up 00 -> 05
        bus.dir = 1'b1; bus.target = 8'h05; bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(19);
        chk("t1_before_last_step", 32'(bus.count), 32'h04);
        wait_neg(1);
        chk("t1_count", 32'(bus.count), 32'h05);
        chk("t1_done",  32'(bus.done),  32'd1);
        chk("t1_state", 32'(bus.state), 32'd3);
        chk("t1_busy",  32'(bus.busy),  32'd0);

        // 2: 97 up through wrap to 02
        bus.load = 1'b1; bus.load_val = 8'h97;
        wait_neg(1); bus.load = 1'b0; bus.target = 8'h02; bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(12);
        chk("t2_wrap_count", 32'(bus.count), 32'h00);
        chk("t2_wrap_flag",  32'(bus.wrap),  32'd1);
        wait_neg(1);
        chk("t2_wrap_one_cycle", 32'(bus.wrap), 32'd0);
        wait_neg(7);
        chk("t2_count", 32'(bus.count), 32'h02);
        chk("t2_state", 32'(bus.state), 32'd3);

        // 3: 01 down through borrow-wrap to 98
        bus.load = 1'b1; bus.load_val = 8'h01;
        wait_neg(1); bus.load = 1'b0; bus.dir = 1'b0; bus.target = 8'h98; bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(4);  chk("t3_zero",  32'(bus.zero),  32'd1);
        wait_neg(4);  chk("t3_99",    32'(bus.count), 32'h99);
        wait_neg(4);  chk("t3_98",    32'(bus.count), 32'h98);
        chk("t3_state", 32'(bus.state), 32'd3);

        // 4: pause at 03, resume takes a full step period
        bus.load = 1'b1; bus.load_val = 8'h02;
        wait_neg(1); bus.load = 1'b0; bus.dir = 1'b1; bus.target = 8'h50; bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(4);
        chk("t4_at_03", 32'(bus.count), 32'h03);
        wait_neg(1); bus.pause = 1'b1;
        wait_neg(10);
        chk("t4_hold_count", 32'(bus.count), 32'h03);
        chk("t4_hold_state", 32'(bus.state), 32'd2);
        bus.pause = 1'b0; bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(3);
        chk("t4_not_yet", 32'(bus.count), 32'h03);
        wait_neg(1);
        chk("t4_step_04", 32'(bus.count), 32'h04);

        // 5: load ignored in RUN, clear beats load, clamp on load
        bus.load = 1'b1; bus.load_val = 8'h50;
        wait_neg(1); bus.load = 1'b0;
        chk("t5_load_ignored", 32'(bus.count), 32'h04);
        chk("t5_still_run",    32'(bus.state), 32'd1);
        bus.clear = 1'b1; bus.load = 1'b1;
        wait_neg(1); bus.clear = 1'b0; bus.load = 1'b0;
        chk("t5_clear_count", 32'(bus.count), 32'h00);
        chk("t5_clear_state", 32'(bus.state), 32'd0);
        bus.load = 1'b1; bus.load_val = 8'hA7;
        wait_neg(1); bus.load = 1'b0;
        chk("t5_clamp", 32'(bus.count), 32'h97);

        // 6: reset mid-run, then restart from 00
        bus.load = 1'b1; bus.load_val = 8'h41;
        wait_neg(1); bus.load = 1'b0; bus.target = 8'h99; bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(4);
        chk("t6_at_42", 32'(bus.count), 32'h42);
        wait_neg(1); rst = 1'b1;
        wait_neg(1); rst = 1'b0;
        chk("t6_rst_count", 32'(bus.count), 32'h00);
        chk("t6_rst_zero",  32'(bus.zero),  32'd1);
        chk("t6_rst_state", 32'(bus.state), 32'd0);
        bus.start = 1'b1;
        wait_neg(1); bus.start = 1'b0;
        wait_neg(3);
        chk("t6_not_yet", 32'(bus.count), 32'h00);
        wait_neg(1);
        chk("t6_first_step", 32'(bus.count), 32'h01);

        // Randomized phase checked by the scoreboard.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            bus.clear = ($urandom_range(0, 59) == 0);
            bus.load  = ($urandom_range(0, 19) == 0);
            bus.pause = ($urandom_range(0, 11) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) bus.dir = ~bus.dir;
            bus.load_val = W'($urandom);
            if ($urandom_range(0, 49) == 0) bus.target = rand_bcd();
            wait_neg(1);
        end
        rst = 1'b0; bus.clear = 1'b0; bus.load = 1'b0; bus.pause = 1'b0; bus.start = 1'b0;
        wait_neg(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
